// File: rtl/lcd_fb_reader.sv
// -----------------------------------------------------------------------------
// lcd_fb_reader
//
// Streams one frame of 16-bit RGB565 pixels out of SDRAM (through the external
// bridge) into a small pixel FIFO that feeds a ready/valid pixel consumer.
// Only one bridge read is ever outstanding. Each completed read is followed
// by a one-cycle GAP, so a word can be fetched at most once every 2 cycles.
//
// Ports
//   clk_clk            : single clock for all logic
//   reset_reset        : synchronous active-high reset
//   start              : one-cycle pulse, begins a frame (ignored while busy)
//   busy               : high from start until the last pixel is accepted
//   frame_done         : one-cycle pulse, the cycle after the last pixel is accepted
//   bridge_address     : byte address of the current read (always even)
//   bridge_byte_enable : constant 2'b11
//   bridge_read        : read request, held until bridge_acknowledge
//   bridge_write       : constant 0
//   bridge_write_data  : constant 16'h0000
//   bridge_acknowledge : read completion, ignored while bridge_read=0
//   bridge_read_data   : read data, sampled on the acknowledge cycle
//   pix_data           : pixel at the FIFO head
//   pix_valid          : FIFO not empty
//   pix_ready          : consumer accepts the head pixel when pix_valid=1
//   pix_last           : head pixel is the last pixel of the frame
// -----------------------------------------------------------------------------
module lcd_fb_reader #(
    parameter logic [22:0] FB_BASE     = 23'h000000,
    parameter int          FRAME_WORDS = 76800,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic [22:0] bridge_address,
    output logic [1:0]  bridge_byte_enable,
    output logic        bridge_read,
    output logic        bridge_write,
    output logic [15:0] bridge_write_data,
    input  logic        bridge_acknowledge,
    input  logic [15:0] bridge_read_data,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last
);

    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FRAME_WORDS_C = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX_C    = CNT_W'(FRAME_WORDS - 1);
    localparam logic [OCC_W-1:0] DEPTH_C       = OCC_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             read_q,     read_d;
    // Word address: byte address bit 0 is structurally zero.
    logic [22:1]      addr_q,     addr_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;   // words fetched this frame
    logic [CNT_W-1:0] pix_cnt_q,  pix_cnt_d;    // index of the pixel at the FIFO head

    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q,    occ_d;

    logic ack_fire, push, pop, last_pop, room_now, room_next;

    assign ack_fire  = read_q && bridge_acknowledge;
    assign push      = ack_fire && (occ_q != DEPTH_C);
    assign pop       = pix_valid && pix_ready;
    assign last_pop  = pop && pix_last;

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // The only read that could be outstanding is the one being issued, so the
    // room test is simply "FIFO not full" on the relevant cycle.
    assign room_now  = occ_q < DEPTH_C;
    assign room_next = occ_d < DEPTH_C;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        read_d     = read_q;
        addr_d     = addr_q;
        word_cnt_d = word_cnt_q;
        pix_cnt_d  = pix_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !busy_q) begin
                    state_d    = ST_REQ;
                    busy_d     = 1'b1;
                    addr_d     = FB_BASE[22:1];
                    word_cnt_d = '0;
                    pix_cnt_d  = '0;
                    read_d     = room_next;
                end
            end
            ST_REQ: begin
                if (read_q) begin
                    // Request and address stay frozen until the bridge answers.
                    if (ack_fire) begin
                        state_d    = ST_GAP;
                        read_d     = 1'b0;
                        addr_d     = addr_q + 22'd1;
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end else begin
                    read_d = room_now;
                end
            end
            ST_GAP: begin
                if (word_cnt_q < FRAME_WORDS_C) begin
                    state_d = ST_REQ;
                    read_d  = room_next;
                end else begin
                    // All words fetched: park in IDLE, busy stays up until drained.
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
            end
        endcase

        if (pop) begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
            if (last_pop) begin
                pix_cnt_d = '0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
                read_d    = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            read_q     <= 1'b0;
            addr_q     <= FB_BASE[22:1];
            word_cnt_q <= '0;
            pix_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            word_cnt_q <= word_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            occ_q      <= occ_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // NOTE: the FIFO storage has no reset; occupancy and pointers define which
    // entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk_clk) begin
        if (push) mem_q[wr_ptr_q] <= bridge_read_data;
    end

    assign pix_valid = occ_q != '0;
    assign pix_data  = mem_q[rd_ptr_q];
    assign pix_last  = pix_valid && (pix_cnt_q == LAST_IDX_C);

    assign busy               = busy_q;
    assign frame_done         = done_q;
    assign bridge_read        = read_q;
    assign bridge_address     = {addr_q, 1'b0};
    assign bridge_byte_enable = 2'b11;
    assign bridge_write       = 1'b0;
    assign bridge_write_data  = 16'h0000;

endmodule

// File: doc/lcd_fb_reader.md
LCD_FB_READER -- requirements
Module: lcd_fb_reader

Interface
REQ-001 SHALL have parameter FB_BASE, default 23'h000000, frame buffer byte address (even).
REQ-002 SHALL have parameter FRAME_WORDS, default 76800, 16-bit pixels per frame (320x240).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of 2, >=4).
REQ-004 SHALL have port clk_clk, input, 1, single clock for all logic.
REQ-005 SHALL have port reset_reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle pulse that begins a frame fetch.
REQ-007 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-008 SHALL have port frame_done, output, 1, one-cycle pulse when the last pixel is consumed.
REQ-009 SHALL have port bridge_address, output, 23, byte address to the SDRAM external bridge.
REQ-010 SHALL have port bridge_byte_enable, output, 2, driven 2'b11.
REQ-011 SHALL have port bridge_read, output, 1, read request.
REQ-012 SHALL have port bridge_write, output, 1, driven 0.
REQ-013 SHALL have port bridge_write_data, output, 16, driven 16'h0000.
REQ-014 SHALL have port bridge_acknowledge, input, 1, transfer completion from the bridge.
REQ-015 SHALL have port bridge_read_data, input, 16, read data, valid when bridge_acknowledge=1.
REQ-016 SHALL have port pix_data, output, 16, RGB565 pixel at FIFO head.
REQ-017 SHALL have port pix_valid, output, 1, pix_data valid (FIFO not empty).
REQ-018 SHALL have port pix_ready, input, 1, consumer accepts pixel when pix_valid and pix_ready are both 1.
REQ-019 SHALL have port pix_last, output, 1, high with pix_valid on the frame's final pixel.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, GAP; only one read outstanding at any time.
REQ-021 IDLE: on start=1, SHALL load word counter to 0, load address to FB_BASE, set busy=1 and enter REQ on the next edge; start while busy=1 SHALL be ignored.
REQ-022 REQ: SHALL assert bridge_read only when FIFO count plus outstanding reads < FIFO_DEPTH; once asserted, bridge_read and bridge_address SHALL hold stable until a cycle with bridge_acknowledge=1.
REQ-023 On an acknowledge cycle, SHALL push bridge_read_data into the FIFO, add 2 to the address, increment the word counter, and deassert bridge_read on the next edge (enter GAP).
REQ-024 GAP: SHALL last exactly one cycle; SHALL then enter REQ if word counter < FRAME_WORDS, else stay idle on the bridge and wait for the FIFO to drain.
REQ-025 Minimum read issue period SHALL be 2 cycles per word; bridge_address bit 0 SHALL always be 0.
REQ-026 bridge_acknowledge SHALL be ignored whenever bridge_read=0 (including IDLE and GAP).
REQ-027 FIFO: a push and a pop in the same cycle SHALL leave count unchanged; no push SHALL occur when full; no pop SHALL occur when empty (pix_valid=0).
REQ-028 pix_data and pix_valid SHALL reflect FIFO head combinationally from registered state; an acknowledge written to an empty FIFO SHALL set pix_valid=1 on the next cycle.
REQ-029 pix_last SHALL be 1 only when pix_valid=1 and the head entry is pixel index FRAME_WORDS-1.
REQ-030 When the pixel with pix_last=1 is accepted, frame_done SHALL pulse for one cycle on the next cycle, busy SHALL drop to 0 in the same cycle, and the FSM SHALL be in IDLE.
REQ-031 Word counter SHALL be wide enough for FRAME_WORDS with no wrap; address arithmetic SHALL wrap modulo 2^23.

Reset
REQ-032 With reset_reset=1 at an edge, SHALL set FSM=IDLE, FIFO empty, and busy, frame_done, bridge_read, pix_valid and pix_last=0; bridge_address SHALL be set to FB_BASE and the counter to 0.
REQ-033 Reset during an outstanding read SHALL abandon that read; any later acknowledge SHALL be discarded per REQ-026.

Verification
REQ-034 FRAME_WORDS=4, ack 1 cycle after read, pix_ready=1 -> addresses 0,2,4,6 are issued and 4 pixels are output in order; frame_done pulses once; busy=0 afterward.
REQ-035 pix_ready=0 and FIFO_DEPTH=4 -> exactly 4 reads complete and bridge_read stays 0; after one pop, exactly one more read issues.
REQ-036 Ack delayed 5 cycles -> bridge_read and address are held constant for all 5 cycles; the data is pushed only on the ack cycle.
REQ-037 start pulsed while busy=1 -> no counter or address reset; the frame completes normally with FRAME_WORDS pixels.
REQ-038 reset_reset asserted mid-read, then a stray ack -> all outputs go to 0 and the FIFO is empty; the ack is ignored; the next start fetches from FB_BASE.
REQ-039 Simultaneous push and pop at count=FIFO_DEPTH-1 -> the count holds; no overflow and no data loss (checked by scoreboard against the bridge model).
